// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: hazard/branch/SRAM-wait events to pipeline freeze, bubble and flush strobes
module pipeline_stall_controller #(
    parameter int CNT_W   = 16,
    parameter int TO_W    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_r_req,
    input  logic             mem_w_req,
    input  logic             mem_ready,
    input  logic             perf_clr,
    output logic             freeze_if,
    output logic             bubble_id_ex,
    output logic             flush_if_id,
    output logic             freeze_all,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_ERR} state_t;
    state_t          state, state_nx;
    logic [TO_W-1:0] cnt, cnt_nx;
    logic            mem_req;
    assign mem_req = mem_r_req | mem_w_req;
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state == RUN) begin
            state_nx = (mem_req && !mem_ready) ? MEM_WAIT : RUN;
            cnt_nx   = (mem_req && !mem_ready) ? TO_W'(1) : cnt;
        end else if (state == MEM_WAIT) begin
            state_nx = mem_ready ? RUN : (cnt == TO_W'(TIMEOUT)) ? MEM_ERR : MEM_WAIT;
            cnt_nx   = mem_ready ? '0 : (cnt == TO_W'(TIMEOUT)) ? cnt : cnt + 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    // Strobes are Mealy and forced low while reset is held, independent of the clock
    assign freeze_all   = !rst && ((state == RUN && mem_req && !mem_ready) ||
                                   (state == MEM_WAIT && !mem_ready) || state == MEM_ERR);
    assign freeze_if    = !rst && (freeze_all || (!branch_taken && hazard_detected));
    assign bubble_id_ex = !rst && !freeze_all && (branch_taken || hazard_detected);
    assign flush_if_id  = !rst && !freeze_all && branch_taken;
    assign mem_error    = state == MEM_ERR;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cycles <= '0;
        else if (perf_clr) stall_cycles <= '0;
        else if (freeze_if && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
    end
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: directed checks of strobes, SRAM wait FSM and stall counter
module tb_pipeline_stall_controller;
    logic       clk = 0, rst = 1;
    logic       hazard_detected = 0, branch_taken = 0, mem_r_req = 0, mem_w_req = 0;
    logic       mem_ready = 0, perf_clr = 0;
    logic       freeze_if, bubble_id_ex, flush_if_id, freeze_all, mem_error;
    logic [3:0] stall_cycles;
    int         checks = 0, errors = 0;

    pipeline_stall_controller #(.CNT_W(4), .TO_W(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
        .mem_r_req(mem_r_req), .mem_w_req(mem_w_req), .mem_ready(mem_ready), .perf_clr(perf_clr),
        .freeze_if(freeze_if), .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id),
        .freeze_all(freeze_all), .mem_error(mem_error), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // strobe vector order: {freeze_if, bubble_id_ex, flush_if_id, freeze_all}
    task automatic chk_s(input string tag, input logic [3:0] exp);
        #1 chk(tag, {28'd0, freeze_if, bubble_id_ex, flush_if_id, freeze_all}, {28'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        chk_s("reset_strobes", 4'b0000);
        tick();
        tick();
        rst = 0;
        chk("reset_stall", 32'(stall_cycles), 0);
        chk("reset_err", 32'(mem_error), 0);

        hazard_detected = 1;
        chk_s("haz_c1", 4'b1100);
        tick();
        chk("haz_stall1", 32'(stall_cycles), 1);
        chk_s("haz_c2", 4'b1100);
        tick();
        chk("haz_stall2", 32'(stall_cycles), 2);

        branch_taken = 1;
        chk_s("br_haz", 4'b0110);
        tick();
        chk("br_stall", 32'(stall_cycles), 2);
        branch_taken = 0;
        hazard_detected = 0;
        chk_s("idle", 4'b0000);

        perf_clr = 1;
        tick();
        perf_clr = 0;
        chk("clr", 32'(stall_cycles), 0);
        mem_r_req = 1;
        branch_taken = 1;
        chk_s("rd_w1", 4'b1001);
        tick();
        chk_s("rd_w2", 4'b1001);
        tick();
        chk_s("rd_w3", 4'b1001);
        tick();
        branch_taken = 0;
        mem_ready = 1;
        chk_s("rd_ready", 4'b0000);
        tick();
        chk("rd_stall", 32'(stall_cycles), 3);
        mem_r_req = 0;
        mem_ready = 0;
        chk_s("rd_back_run", 4'b0000);

        perf_clr = 1;
        tick();
        perf_clr = 0;
        mem_w_req = 1;
        for (int i = 0; i < 16; i++) begin
            chk_s("wr_frozen", 4'b1001);
            chk("wr_noerr", 32'(mem_error), 0);
            tick();
        end
        chk("wr_err", 32'(mem_error), 1);
        chk("wr_stall_sat", 32'(stall_cycles), 15);
        mem_ready = 1;
        chk_s("err_stuck", 4'b1001);
        tick();
        chk("err_sticky", 32'(mem_error), 1);
        rst = 1;
        chk_s("err_rst_strobes", 4'b0000);
        chk("err_rst_clr", 32'(mem_error), 0);
        #1 rst = 0;
        mem_w_req = 0;
        mem_ready = 0;
        chk_s("err_rst_run", 4'b0000);

        tick();
        mem_r_req = 1;
        tick();
        chk_s("mid_wait", 4'b1001);
        rst = 1;
        chk_s("mid_rst_async", 4'b0000);
        #1 rst = 0;
        mem_r_req = 0;
        chk_s("mid_rst_run", 4'b0000);

        tick();
        hazard_detected = 1;
        for (int i = 0; i < 20; i++) tick();
        chk("sat", 32'(stall_cycles), 15);
        perf_clr = 1;
        tick();
        chk("sat_clr", 32'(stall_cycles), 0);
        perf_clr = 0;
        tick();
        chk("after_clr", 32'(stall_cycles), 1);
        hazard_detected = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
